// File: rtl/cp0_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_ctrl_pkg
//  Description : Shared CP0 definitions: exception codes, register numbers,
//                SR/Cause bit positions, FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package cp0_ctrl_pkg;

    // Exception codes in the 6-bit {valid, ExcCode} form
    localparam logic [5:0] EXC_NONE = 6'h00;
    localparam logic [5:0] EXC_PCAD = 6'h24;
    localparam logic [5:0] EXC_DRAD = 6'h24;
    localparam logic [5:0] EXC_DWAD = 6'h25;
    localparam logic [5:0] EXC_ILOP = 6'h2A;
    localparam logic [5:0] EXC_OVER = 6'h2C;

    // CP0 register numbers
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // SR / Cause bit positions
    localparam int unsigned SR_IE       = 0;
    localparam int unsigned SR_EXL      = 1;
    localparam int unsigned SR_IM_LO    = 10;
    localparam int unsigned SR_IM_HI    = 15;
    localparam int unsigned CAUSE_BD    = 31;
    localparam int unsigned CAUSE_IP_LO = 10;
    localparam int unsigned CAUSE_EXC_LO = 2;

    // Blackout FSM states
    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_BLACK  = 1'b1;

    // Values captured into EPC/Cause when a trap is taken
    typedef struct packed {
        logic [31:0] epc;
        logic        bd;
        logic [4:0]  code;
    } trap_info_t;

endpackage : cp0_ctrl_pkg
`default_nettype wire

// File: rtl/cp0_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_ctrl_if
//  Description : M-stage to CP0 bus: exception/eret/mtc0 inputs, interrupt
//                lines, and the flush/redirect/read-back outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cp0_ctrl_if;
    logic [5:0]  exception;
    logic [31:0] pcm;
    logic        bdm;
    logic        valid_m;
    logic [5:0]  hw_int;
    logic        we;
    logic        eret_m;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] epc;
    logic        general_flush;
    logic        redirect;
    logic [31:0] next_pc;
    logic        exl;

    // Pipeline side
    modport master (
        output exception, pcm, bdm, valid_m, hw_int, we, eret_m, addr, din,
        input  dout, epc, general_flush, redirect, next_pc, exl
    );

    // CP0 side
    modport slave (
        input  exception, pcm, bdm, valid_m, hw_int, we, eret_m, addr, din,
        output dout, epc, general_flush, redirect, next_pc, exl
    );
endinterface : cp0_ctrl_if
`default_nettype wire

// File: rtl/cp0_ctrl_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_ctrl_regfile
//  Description : SR / Cause / EPC storage with PRId constant and read mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_ctrl_regfile
    import cp0_ctrl_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h4D49_5053
) (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic [5:0]  hw_int,
    input  wire logic        trap,
    input  wire trap_info_t  trap_info,
    input  wire logic        eret,
    input  wire logic        wr_en,
    input  wire logic [4:0]  addr,
    input  wire logic [31:0] din,
    output      logic [31:0] dout,
    output      logic [5:0]  im,
    output      logic        exl,
    output      logic        ie,
    output      logic [31:0] epc
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_code;
    logic [31:0] r_epc;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    // Register update: trap capture beats eret, eret beats mtc0; IP always tracks lines
    always_ff @(posedge clock) begin
        if (reset) begin
            r_im   <= '0;
            r_exl  <= 1'b0;
            r_ie   <= 1'b0;
            r_bd   <= 1'b0;
            r_ip   <= '0;
            r_code <= '0;
            r_epc  <= '0;
        end else begin
            r_ip <= hw_int;
            if (trap) begin
                r_epc  <= trap_info.epc;
                r_bd   <= trap_info.bd;
                r_code <= trap_info.code;
                r_exl  <= 1'b1;
            end else if (eret) begin
                r_exl <= 1'b0;
            end else if (wr_en) begin
                case (addr)
                    REG_SR: begin
                        r_im  <= din[SR_IM_HI:SR_IM_LO];
                        r_exl <= din[SR_EXL];
                        r_ie  <= din[SR_IE];
                    end
                    REG_EPC: r_epc <= din;
                    default: ;
                endcase
            end
        end
    end

    assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_code, 2'b0};

    // Combinational mfc0 read; unmapped numbers read as zero
    always_comb begin
        dout = '0;
        case (addr)
            REG_SR:    dout = w_sr;
            REG_CAUSE: dout = w_cause;
            REG_EPC:   dout = r_epc;
            REG_PRID:  dout = PRID;
            default:   dout = '0;
        endcase
    end

    assign im  = r_im;
    assign exl = r_exl;
    assign ie  = r_ie;
    assign epc = r_epc;

endmodule : cp0_ctrl_regfile
`default_nettype wire

// File: rtl/cp0_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_ctrl
//  Description : CP0 exception controller: trap/eret arbitration, flush and
//                redirect generation, post-eret interrupt blackout FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID       = 32'h4D49_5053,
    parameter int unsigned BLACKOUT   = 1
) (
    input  wire logic clock,
    input  wire logic reset,
    cp0_ctrl_if.slave bus
);

    localparam logic [1:0] BLACK_LOAD = 2'(BLACKOUT - 1);

    logic [0:0]  r_state;
    logic [1:0]  r_cnt;
    logic [5:0]  w_im;
    logic        w_exl;
    logic        w_ie;
    logic [31:0] w_epc;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_trap;
    logic        w_eret;
    logic        w_mtc0;
    trap_info_t  w_info;

    // Interrupts need IE, no EXL, an enabled pending line and no blackout
    assign w_int_req = w_ie & ~w_exl & (|(bus.hw_int & w_im)) & (r_state == ST_NORMAL);
    assign w_exc_req = bus.exception[5] & ~w_exl;
    assign w_trap    = bus.valid_m & (w_int_req | w_exc_req);
    assign w_eret    = bus.valid_m & bus.eret_m & ~w_trap;
    assign w_mtc0    = bus.valid_m & bus.we & ~w_trap & ~bus.eret_m;

    // Delay-slot victims restart at the branch; interrupt takes precedence
    assign w_info.epc  = bus.bdm ? (bus.pcm - 32'd4) : bus.pcm;
    assign w_info.bd   = bus.bdm;
    assign w_info.code = w_int_req ? 5'd0 : bus.exception[4:0];

    cp0_ctrl_regfile #(
        .PRID (PRID)
    ) u_regfile (
        .clock     (clock),
        .reset     (reset),
        .hw_int    (bus.hw_int),
        .trap      (w_trap),
        .trap_info (w_info),
        .eret      (w_eret),
        .wr_en     (w_mtc0),
        .addr      (bus.addr),
        .din       (bus.din),
        .dout      (bus.dout),
        .im        (w_im),
        .exl       (w_exl),
        .ie        (w_ie),
        .epc       (w_epc)
    );

    // Blackout FSM: eret (re)loads the counter, BLACK counts down to NORMAL
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_NORMAL;
            r_cnt   <= '0;
        end else if (w_eret) begin
            r_state <= ST_BLACK;
            r_cnt   <= BLACK_LOAD;
        end else if (r_state == ST_BLACK) begin
            if (r_cnt == 2'd0) begin
                r_state <= ST_NORMAL;
            end else begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    // Reset suppresses any same-cycle flush so a held reset never redirects
    assign bus.general_flush = ~reset & (w_trap | w_eret);
    assign bus.redirect      = ~reset & (w_trap | w_eret);
    assign bus.next_pc       = (~reset & w_eret) ? w_epc : HANDLER_PC;
    assign bus.epc           = w_epc;
    assign bus.exl           = w_exl;

endmodule : cp0_ctrl
`default_nettype wire
